imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: mem_addr  output  17  byte address to instruction memory, {pc, beat}.
REQ-004 SHALL have port: mem_req  output  1  byte read request.
REQ-005 SHALL have port: mem_ack  input  1  memory has placed valid data on mem_rdata this cycle.
REQ-006 SHALL have port: mem_rdata  input  8  read byte.
REQ-007 SHALL have port: instr  output  16  fetched instruction; bits [15:13] drive the control decoder opcode.
REQ-008 SHALL have port: instr_valid  output  1  instr holds a complete instruction for the current pc.
REQ-009 SHALL have port: instr_ready  input  1  execute stage retires instr this cycle.
REQ-010 SHALL have port: mux_pc  input  2  next-PC select from control: 00 hold, 01 next, 10 branch, 11 jump.
REQ-011 SHALL have port: br_off  input  16  sign-extended branch offset, in words.
REQ-012 SHALL have port: jump_tgt  input  16  absolute jump target word address.
REQ-013 SHALL have port: pc  output  16  word address of instruction being fetched/presented.
REQ-014 SHALL have parameter: RESET_PC, 16'h0000, pc value loaded on reset.

Function
REQ-015 SHALL implement FSM states FETCH_HI, FETCH_LO, VALID; reset state FETCH_HI.
REQ-016 SHALL in FETCH_HI drive mem_req=1, mem_addr={pc,1'b0}; on mem_ack capture mem_rdata into instr[15:8], go FETCH_LO.
REQ-017 SHALL in FETCH_LO drive mem_req=1, mem_addr={pc,1'b1}; on mem_ack capture mem_rdata into instr[7:0], go VALID.
REQ-018 SHALL hold mem_req and mem_addr stable while awaiting mem_ack; wait states unbounded.
REQ-019 SHALL ignore mem_ack when mem_req=0 and in VALID.
REQ-020 SHALL assert instr_valid only in VALID; instr SHALL be stable while instr_valid=1.
REQ-021 SHALL give minimum latency of 2 cycles from entering FETCH_HI to instr_valid=1 (zero-wait ack each beat).
REQ-022 SHALL, in VALID with instr_ready=0, stay in VALID with pc unchanged.
REQ-023 SHALL, in VALID with instr_ready=1, update pc per mux_pc and go FETCH_HI the same edge.
REQ-024 SHALL compute next pc: 01 pc+1; 10 pc+1+br_off; 11 jump_tgt; 00 pc (refetch same address).
REQ-025 SHALL perform pc arithmetic modulo 2^16; pc=16'hFFFF with 01 wraps to 16'h0000.
REQ-026 SHALL sample mux_pc, br_off, jump_tgt only on the retiring edge (VALID and instr_ready=1).
REQ-027 SHALL never present back-to-back instr_valid without an intervening fetch (no prefetch).

Reset
REQ-028 SHALL on rst_n=0 immediately force: pc=RESET_PC, state=FETCH_HI, instr=16'h0000, instr_valid=0, mem_req=0.
REQ-029 SHALL keep mem_req=0 for the first rising edge after rst_n deasserts, asserting it from the following cycle.
REQ-030 SHALL, on reset mid-beat, abandon the transaction; a late mem_ack after reset SHALL be ignored until mem_req reasserts.

Structure
REQ-031 SHALL take MUX_PC_* encodings, FSM state encoding and RESET_PC default from shared package tinyrv_pkg, also used by control.
REQ-032 SHALL place next-pc arithmetic (REQ-024/025) in combinational sub-module pc_next; FSM, pc and instr registers in imem_fetch.

Verification
REQ-033 SHALL cover reset fetch: rst_n release, memory bytes @0=8'h24,@1=8'h81, zero-wait -> mem_addr 0 then 1, instr=16'h2481, pc=0.
REQ-034 SHALL cover wait states: 3-cycle ack delay per beat -> mem_req/mem_addr stable throughout, instr_valid after 8 cycles from first request.
REQ-035 SHALL cover branch: pc=16'h0010, mux_pc=10, br_off=16'hFFFC, retire -> next mem_addr={16'h000D,0}.
REQ-036 SHALL cover jump and wrap: mux_pc=11, jump_tgt=16'hFFFF, then mux_pc=01 -> fetch at FFFF then pc=16'h0000.
REQ-037 SHALL cover stall and hold: instr_ready=0 for 5 cycles -> instr, pc constant; mux_pc=00 retire -> refetch same pc.
REQ-038 SHALL cover reset during FETCH_LO with pending ack -> mem_req=0 at once, pc=RESET_PC, stray ack ignored.

Source files
------------

// File: rtl/tinyrv_pkg.sv
// Shared tinyrv encodings: next-PC select codes, fetch FSM states and reset PC.
// The control block uses the same mux_pc encodings.
package tinyrv_pkg;

   localparam logic [1:0] MUX_PC_HOLD   = 2'b00;
   localparam logic [1:0] MUX_PC_NEXT   = 2'b01;
   localparam logic [1:0] MUX_PC_BRANCH = 2'b10;
   localparam logic [1:0] MUX_PC_JUMP   = 2'b11;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      FETCH_HI = 2'd0,
      FETCH_LO = 2'd1,
      VALID    = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection. All arithmetic wraps modulo 2^16.
module pc_next
   import tinyrv_pkg::*;
(
   input  logic [15:0] pc,
   input  logic [1:0]  mux_pc,
   input  logic [15:0] br_off,
   input  logic [15:0] jump_tgt,
   output logic [15:0] pc_nxt
);

   logic [15:0] pc_inc;

   always_comb begin
      pc_inc = pc + 16'd1;
      pc_nxt = pc;
      case (mux_pc)
         MUX_PC_HOLD:   pc_nxt = pc;
         MUX_PC_NEXT:   pc_nxt = pc_inc;
         MUX_PC_BRANCH: pc_nxt = pc_inc + br_off;
         MUX_PC_JUMP:   pc_nxt = jump_tgt;
         default:       pc_nxt = pc;
      endcase
   end

endmodule

// File: rtl/imem_fetch.sv
// Two-beat byte-wide instruction fetch: high byte then low byte, then present
// the instruction until execute retires it. No prefetch.
module imem_fetch
   import tinyrv_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [16:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic [1:0]  mux_pc,
   input  logic [15:0] br_off,
   input  logic [15:0] jump_tgt,
   output logic [15:0] pc
);

   fetch_state_t state_q, state_d;
   logic [15:0]  pc_q, pc_nxt, instr_q;
   logic         started_q;
   logic         hi_we, lo_we, retire;

   pc_next u_pc_next (
      .pc       (pc_q),
      .mux_pc   (mux_pc),
      .br_off   (br_off),
      .jump_tgt (jump_tgt),
      .pc_nxt   (pc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH_HI;
      else        state_q <= state_d;
   end

   // Holds off the first request for one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) started_q <= 1'b0;
      else        started_q <= 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_addr    = {pc_q, 1'b0};
      instr_valid = 1'b0;
      hi_we       = 1'b0;
      lo_we       = 1'b0;
      retire      = 1'b0;
      case (state_q)
         FETCH_HI: begin
            mem_req  = started_q;
            mem_addr = {pc_q, 1'b0};
            if (started_q && mem_ack) begin
               hi_we   = 1'b1;
               state_d = FETCH_LO;
            end
         end
         FETCH_LO: begin
            mem_req  = 1'b1;
            mem_addr = {pc_q, 1'b1};
            if (mem_ack) begin
               lo_we   = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               retire  = 1'b1;
               state_d = FETCH_HI;
            end
         end
         default: state_d = FETCH_HI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc_q <= RESET_PC;
      else if (retire) pc_q <= pc_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= 16'h0000;
      end else begin
         if (hi_we) instr_q[15:8] <= mem_rdata;
         if (lo_we) instr_q[7:0]  <= mem_rdata;
      end
   end

   assign pc    = pc_q;
   assign instr = instr_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed + randomized bench for imem_fetch against a word-level PC/memory model.
module tb_imem_fetch;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] mem_addr;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [1:0]  mux_pc = 2'b00;
   logic [15:0] br_off = 16'h0000;
   logic [15:0] jump_tgt = 16'h0000;
   logic [15:0] pc;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_pc;
   logic [15:0] m_instr;

   imem_fetch #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .mux_pc      (mux_pc),
      .br_off      (br_off),
      .jump_tgt    (jump_tgt),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: fixed bytes at 0/1, hashed elsewhere.
   function automatic logic [7:0] mem_byte(input logic [16:0] a);
      logic [31:0] h;
      if (a == 17'd0) return 8'h24;
      if (a == 17'd1) return 8'h81;
      h = {15'd0, a} * 32'd2654435761;
      return h[23:16];
   endfunction

   function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [1:0] sel,
                                              input logic [15:0] off, input logic [15:0] tgt);
      int unsigned v;
      case (sel)
         2'b01:   v = int'(cur) + 1;
         2'b10:   v = int'(cur) + 1 + int'(off);
         2'b11:   v = int'(tgt);
         default: v = int'(cur);
      endcase
      return 16'(v % 65536);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One byte beat: request must hold steady through `waits` idle cycles, then ack.
   task automatic serve_beat(input logic [16:0] addr, input int waits, input string tag);
      for (int i = 0; i <= waits; i++) begin
         @(negedge clk);
         instr_ready = 1'($urandom);
         mux_pc      = 2'($urandom);
         br_off      = 16'($urandom);
         jump_tgt    = 16'($urandom);
         chk({tag, "_req"},   32'(mem_req), 32'd1);
         chk({tag, "_addr"},  32'(mem_addr), 32'(addr));
         chk({tag, "_novld"}, 32'(instr_valid), 32'd0);
         if (i == waits) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_byte(addr);
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
         end
      end
   endtask

   task automatic fetch_instr(input int wh, input int wl, input string tag);
      m_instr = {mem_byte({m_pc, 1'b0}), mem_byte({m_pc, 1'b1})};
      serve_beat({m_pc, 1'b0}, wh, {tag, "_hi"});
      serve_beat({m_pc, 1'b1}, wl, {tag, "_lo"});
      @(negedge clk);
      mem_ack     = 1'b0;
      instr_ready = 1'b0;
      chk({tag, "_vld"},   32'(instr_valid), 32'd1);
      chk({tag, "_instr"}, 32'(instr), 32'(m_instr));
      chk({tag, "_pc"},    32'(pc), 32'(m_pc));
      chk({tag, "_noreq"}, 32'(mem_req), 32'd0);
   endtask

   // Stall for `stall` cycles (stray acks and junk selects ignored), then retire.
   task automatic retire(input logic [1:0] sel, input logic [15:0] off, input logic [15:0] tgt,
                         input int stall, input string tag);
      for (int s = 0; s < stall; s++) begin
         instr_ready = 1'b0;
         mux_pc      = 2'($urandom);
         br_off      = 16'($urandom);
         jump_tgt    = 16'($urandom);
         mem_ack     = 1'($urandom);
         mem_rdata   = 8'($urandom);
         @(negedge clk);
         chk({tag, "_hold_vld"},   32'(instr_valid), 32'd1);
         chk({tag, "_hold_instr"}, 32'(instr), 32'(m_instr));
         chk({tag, "_hold_pc"},    32'(pc), 32'(m_pc));
      end
      instr_ready = 1'b1;
      mux_pc      = sel;
      br_off      = off;
      jump_tgt    = tgt;
      mem_ack     = 1'b0;
      m_pc        = model_next(m_pc, sel, off, tgt);
   endtask

   initial begin
      // Power-on reset, with a stray ack across release.
      #1;
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_pc",    32'(pc), 32'(RST_PC));
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_vld",   32'(instr_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 8'hA5;
      rst_n     = 1'b1;
      chk("rel_req0", 32'(mem_req), 32'd0);
      m_pc = RST_PC;

      fetch_instr(0, 0, "reset_fetch");
      chk("reset_fetch_2481", 32'(instr), 32'h2481);

      retire(2'b01, 16'h0, 16'h0, 0, "next");
      fetch_instr(3, 3, "wait3");

      retire(2'b11, 16'h0, 16'h0010, 0, "jmp10");
      fetch_instr(0, 0, "at10");
      retire(2'b10, 16'hFFFC, 16'h0, 1, "branch");
      fetch_instr(0, 1, "branch_tgt");
      chk("branch_pc_0d", 32'(pc), 32'h000D);

      retire(2'b11, 16'h0, 16'hFFFF, 0, "jmpffff");
      fetch_instr(1, 0, "atffff");
      retire(2'b01, 16'h0, 16'h0, 0, "wrap");
      fetch_instr(0, 0, "wrapped");
      chk("wrap_pc_0", 32'(pc), 32'h0000);

      retire(2'b01, 16'h0, 16'h0, 0, "adv");
      fetch_instr(0, 0, "pre_stall");
      retire(2'b00, 16'h0, 16'h0, 5, "stall");
      fetch_instr(0, 0, "refetch");

      // Reset while FETCH_LO has an ack pending.
      retire(2'b01, 16'h0, 16'h0, 0, "pre_rst");
      serve_beat({m_pc, 1'b0}, 0, "rst_mid_hi");
      @(negedge clk);
      chk("rst_mid_lo_addr", 32'(mem_addr), 32'({m_pc, 1'b1}));
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
      #2 rst_n  = 1'b0;
      #1;
      chk("rst_mid_req",   32'(mem_req), 32'd0);
      chk("rst_mid_pc",    32'(pc), 32'(RST_PC));
      chk("rst_mid_instr", 32'(instr), 32'd0);
      chk("rst_mid_vld",   32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("rst_mid_hold_req", 32'(mem_req), 32'd0);
      rst_n = 1'b1;
      chk("rst_mid_rel_req", 32'(mem_req), 32'd0);
      m_pc = RST_PC;
      fetch_instr(1, 0, "post_rst");

      for (int n = 0; n < 40; n++) begin
         retire(2'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rnd_ret");
         fetch_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rnd_fetch");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
